// File: rtl/mor1kx_tlb_reload_wb_pkg.sv
// Shared types and constants for the TLB-reload Wishbone master.
// The state encoding, the owner encoding and the round-robin pick live here.
package mor1kx_tlb_reload_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    localparam logic OWNER_DMMU = 1'b0;
    localparam logic OWNER_IMMU = 1'b1;

    // On contention the requester that was not granted last wins.
    function automatic logic rr_pick(input logic dmmu_req, input logic immu_req,
                                     input logic last_grant);
        logic pick;
        if (dmmu_req && immu_req)
            pick = ~last_grant;
        else if (immu_req)
            pick = OWNER_IMMU;
        else
            pick = OWNER_DMMU;
        return pick;
    endfunction

endpackage

// File: rtl/mor1kx_tlb_reload_wb.sv
// Wishbone read master serving the IMMU/DMMU hardware TLB-reload ports.
// Grants are locked for a whole page-table walk; each read returns one word.
module mor1kx_tlb_reload_wb
    import mor1kx_tlb_reload_wb_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_TLB_RELOAD_TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dmmu_reload_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_reload_addr_i,
    output logic                            dmmu_reload_ack_o,
    input  logic                            immu_reload_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_reload_addr_i,
    output logic                            immu_reload_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] reload_data_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    output logic                            timeout_o
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(OPTION_TLB_RELOAD_TIMEOUT);

    state_t                          state_q, state_d;
    logic                            owner_q, owner_d;
    logic                            last_q, last_d;
    logic                            drop_q, drop_d;
    logic                            dack_q, dack_d;
    logic                            iack_q, iack_d;
    logic                            tout_q, tout_d;
    logic [15:0]                     cnt_q, cnt_d;
    logic [OPTION_OPERAND_WIDTH-1:0] adr_q, adr_d;
    logic [OPTION_OPERAND_WIDTH-1:0] data_q, data_d;

    logic                            grant;
    logic                            owner_req;
    logic [OPTION_OPERAND_WIDTH-1:0] owner_addr;
    logic [15:0]                     cnt_inc;
    logic                            timed_out;

    assign grant      = rr_pick(dmmu_reload_req_i, immu_reload_req_i, last_q);
    assign owner_req  = (owner_q == OWNER_IMMU) ? immu_reload_req_i : dmmu_reload_req_i;
    assign owner_addr = (owner_q == OWNER_IMMU) ? immu_reload_addr_i : dmmu_reload_addr_i;
    assign cnt_inc    = cnt_q + 16'd1;
    // The count includes the current BUS cycle, so a limit of N allows N BUS cycles.
    assign timed_out  = (TIMEOUT_LIM != 16'd0) && (cnt_inc == TIMEOUT_LIM);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        data_d  = data_q;
        dack_d  = 1'b0;
        iack_d  = 1'b0;
        tout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dmmu_reload_req_i || immu_reload_req_i) begin
                    owner_d = grant;
                    last_d  = grant;
                    adr_d   = (grant == OWNER_IMMU) ? immu_reload_addr_i : dmmu_reload_addr_i;
                    cnt_d   = 16'd0;
                    drop_d  = 1'b0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_inc;
                if (!owner_req)
                    drop_d = 1'b1;
                if (wbm_err_i || wbm_ack_i || timed_out) begin
                    state_d = ST_RESP;
                    data_d  = (wbm_ack_i && !wbm_err_i) ? wbm_dat_i : '0;
                    tout_d  = timed_out && !wbm_ack_i && !wbm_err_i;
                    // A requester that let go mid-transfer gets no response.
                    if (!drop_q && owner_req) begin
                        dack_d = (owner_q == OWNER_DMMU);
                        iack_d = (owner_q == OWNER_IMMU);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (owner_req) begin
                    adr_d   = owner_addr;
                    cnt_d   = 16'd0;
                    drop_d  = 1'b0;
                    state_d = ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_DMMU;
            last_q  <= OWNER_IMMU;
            drop_q  <= 1'b0;
            cnt_q   <= 16'd0;
            adr_q   <= '0;
            data_q  <= '0;
            dack_q  <= 1'b0;
            iack_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            dack_q  <= dack_d;
            iack_q  <= iack_d;
            tout_q  <= tout_d;
        end
    end

    assign wbm_cyc_o         = (state_q == ST_BUS);
    assign wbm_stb_o         = (state_q == ST_BUS);
    assign wbm_adr_o         = adr_q;
    assign wbm_we_o          = 1'b0;
    assign wbm_sel_o         = 4'hf;
    assign wbm_cti_o         = WB_CTI_CLASSIC;
    assign wbm_bte_o         = WB_BTE_LINEAR;
    assign reload_data_o     = data_q;
    assign dmmu_reload_ack_o = dack_q;
    assign immu_reload_ack_o = iack_q;
    assign timeout_o         = tout_q;

endmodule
